// File: rtl/score_display.sv
// Binary-to-BCD display stage: sequential double-dabble conversion, then two digits
// time-multiplexed onto one 7-segment bus. Optional macro: SCORE_DISPLAY_LEADING_BLANK_EN.
module score_display #(
    parameter int BW         = 7,
    parameter int REFRESH_BW = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic          digit_o,
    output logic          upd_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    localparam int CW = $clog2(BW + 1);
    localparam int SW = 8 + BW;
    localparam logic [BW-1:0] MAX_SHOWN = BW'(99);
    localparam logic [CW-1:0] LAST_ITER = CW'(BW - 1);

    // Exposed for hierarchical inspection of the conversion FSM.
    logic [1:0]            state;
    logic [CW-1:0]         iter;
    logic [SW-1:0]         sr;
    logic                  over;
    logic [3:0]            disp_tens;
    logic [3:0]            disp_ones;
    logic                  disp_over;
    logic [REFRESH_BW-1:0] refresh;
    logic                  digit_next;
    logic [6:0]            seg_next;

    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        if (t[SW-1 -: 4] >= 4'd5) t[SW-1 -: 4] = t[SW-1 -: 4] + 4'd3;
        if (t[BW+3 -: 4] >= 4'd5) t[BW+3 -: 4] = t[BW+3 -: 4] + 4'd3;
        return {t[SW-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            iter      <= '0;
            sr        <= '0;
            over      <= 1'b0;
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
            disp_over <= 1'b0;
            upd_o     <= 1'b0;
        end else begin
            upd_o <= 1'b0;
            case (state)
                IDLE: begin
                    sr    <= {8'd0, value_i};
                    over  <= (value_i > MAX_SHOWN);
                    iter  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr   <= dabble_step(sr);
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER) state <= LOAD;
                end
                LOAD: begin
                    disp_tens <= sr[SW-1 -: 4];
                    disp_ones <= sr[BW+3 -: 4];
                    disp_over <= over;
                    upd_o     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Segments follow the digit that will be selected after this edge, so the
    // bus and the select line always change together.
    always_comb begin
        digit_next = digit_o ^ (&refresh);
        seg_next   = 7'h00;
        if (disp_over) begin
            seg_next = 7'h40;
        end else if (digit_next) begin
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
            seg_next = (disp_tens == 4'd0) ? 7'h00 : seg_of(disp_tens);
`else
            seg_next = seg_of(disp_tens);
`endif
        end else begin
            seg_next = seg_of(disp_ones);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            refresh <= '0;
            digit_o <= 1'b0;
            seg_o   <= 7'h3F;
        end else begin
            refresh <= refresh + 1'b1;
            digit_o <= digit_next;
            seg_o   <= seg_next;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short refresh counter; build with or
// without SCORE_DISPLAY_LEADING_BLANK_EN.
module tb_score_display;

    localparam int BW    = 7;
    localparam int RB    = 4;
    localparam int FRAME = 1 << (RB + 1);

`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] value = '0;
    logic [6:0]    seg;
    logic          digit;
    logic          upd;

    int checks = 0;
    int errors = 0;

    score_display #(.BW(BW), .REFRESH_BW(RB)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .value_i (value),
        .seg_o   (seg),
        .digit_o (digit),
        .upd_o   (upd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_upd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd) seen = 1'b1;
        end
    endtask

    task automatic load_value(input logic [BW-1:0] v, output bit ok);
        bit s1, s2;
        value = v;
        wait_upd(s1);
        wait_upd(s2);
        ok = s1 && s2;
    endtask

    // Records the segment pattern seen on each digit over a full frame.
    task automatic observe_frame(output logic [6:0] s0, output logic [6:0] s1,
                                 output bit stable, output bit both);
        bit saw0, saw1;
        s0 = '0; s1 = '0; stable = 1'b1; saw0 = 1'b0; saw1 = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!digit) begin
                if (saw0 && seg !== s0) stable = 1'b0;
                s0 = seg; saw0 = 1'b1;
            end else begin
                if (saw1 && seg !== s1) stable = 1'b0;
                s1 = seg; saw1 = 1'b1;
            end
        end
        both = saw0 && saw1;
    endtask

    task automatic test_reset;
        logic [6:0] s0, s1;
        bit stable, both;
        rst_n = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h, required 3f", seg); end
        checks++; if (digit !== 1'b0) begin errors++; $display("FAIL reset_digit: got %b, required 0", digit); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b, required 0", upd); end
        rst_n = 1'b1;
        repeat (15) begin @(posedge clk); @(negedge clk); end
        checks++; if (digit !== 1'b0) begin errors++; $display("FAIL refresh_hold0: got %b, required 0", digit); end
        @(posedge clk); @(negedge clk);
        checks++; if (digit !== 1'b1) begin errors++; $display("FAIL refresh_toggle1: got %b, required 1", digit); end
        repeat (15) begin @(posedge clk); @(negedge clk); end
        checks++; if (digit !== 1'b1) begin errors++; $display("FAIL refresh_hold1: got %b, required 1", digit); end
        @(posedge clk); @(negedge clk);
        checks++; if (digit !== 1'b0) begin errors++; $display("FAIL refresh_toggle0: got %b, required 0", digit); end
        observe_frame(s0, s1, stable, both);
        checks++; if (!both || !stable) begin errors++; $display("FAIL zero_frame: both=%b stable=%b, required 1 1", both, stable); end
        checks++; if (s0 !== 7'h3F) begin errors++; $display("FAIL zero_ones: got %h, required 3f", s0); end
        checks++; if (s1 !== TENS_ZERO) begin errors++; $display("FAIL zero_tens: got %h, required %h", s1, TENS_ZERO); end
    endtask

    task automatic test_value_42;
        logic [6:0] s0, s1;
        bit stable, both, ok, seen;
        int n;
        load_value(7'd42, ok);
        checks++; if (!ok) begin errors++; $display("FAIL v42_load: upd seen=%b, required 1", ok); end
        wait_upd(seen);
        n = 0;
        @(posedge clk); @(negedge clk);
        n++;
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL v42_pulse_width: upd=%b one cycle after pulse, required 0", upd); end
        while (!upd && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        checks++; if (n !== 9) begin errors++; $display("FAIL v42_period: got %0d cycles, required 9", n); end
        observe_frame(s0, s1, stable, both);
        checks++; if (!both || !stable) begin errors++; $display("FAIL v42_frame: both=%b stable=%b, required 1 1", both, stable); end
        checks++; if (s0 !== 7'h5B) begin errors++; $display("FAIL v42_ones: got %h, required 5b", s0); end
        checks++; if (s1 !== 7'h66) begin errors++; $display("FAIL v42_tens: got %h, required 66", s1); end
    endtask

    task automatic test_boundary;
        logic [BW-1:0] vals [4] = '{7'd99, 7'd100, 7'd127, 7'd7};
        logic [6:0]    exp1 [4] = '{7'h6F, 7'h40, 7'h40, TENS_ZERO};
        logic [6:0]    exp0 [4] = '{7'h6F, 7'h40, 7'h40, 7'h07};
        logic [6:0] s0, s1;
        bit stable, both, ok;
        for (int k = 0; k < 4; k++) begin
            load_value(vals[k], ok);
            observe_frame(s0, s1, stable, both);
            checks++; if (!ok || !both || !stable) begin errors++; $display("FAIL bound_frame v=%0d: ok=%b both=%b stable=%b, required 1 1 1", vals[k], ok, both, stable); end
            checks++; if (s0 !== exp0[k]) begin errors++; $display("FAIL bound_ones v=%0d: got %h, required %h", vals[k], s0, exp0[k]); end
            checks++; if (s1 !== exp1[k]) begin errors++; $display("FAIL bound_tens v=%0d: got %h, required %h", vals[k], s1, exp1[k]); end
        end
    endtask

    task automatic test_sample_hold;
        bit ok, seen;
        logic [6:0] exp;
        load_value(7'd12, ok);
        @(posedge clk); @(negedge clk);
        value = 7'd35;
        wait_upd(seen);
        checks++; if (!ok || !seen) begin errors++; $display("FAIL hold_upd12: ok=%b seen=%b, required 1 1", ok, seen); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            exp = digit ? 7'h06 : 7'h5B;
            checks++; if (seg !== exp) begin errors++; $display("FAIL hold_show12 c%0d: got %h, required %h", i, seg, exp); end
        end
        wait_upd(seen);
        checks++; if (!seen) begin errors++; $display("FAIL hold_upd35: seen=%b, required 1", seen); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            exp = digit ? 7'h4F : 7'h6D;
            checks++; if (seg !== exp) begin errors++; $display("FAIL hold_show35 c%0d: got %h, required %h", i, seg, exp); end
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] s0, s1;
        bit stable, both, ok, seen, blank_ok;
        int n;
        load_value(7'd88, ok);
        wait_upd(seen);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL mid_rst_seg: got %h, required 3f", seg); end
        checks++; if (digit !== 1'b0) begin errors++; $display("FAIL mid_rst_digit: got %b, required 0", digit); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL mid_rst_upd: got %b, required 0", upd); end
        rst_n = 1'b1;
        n = 0;
        blank_ok = 1'b1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (upd) seen = 1'b1;
            else if (seg !== 7'h3F || digit !== 1'b0) blank_ok = 1'b0;
        end
        checks++; if (n !== 9) begin errors++; $display("FAIL mid_first_upd: got %0d cycles, required 9", n); end
        checks++; if (!blank_ok) begin errors++; $display("FAIL mid_pre_load: display left 3f/digit0 before first load, required hold"); end
        observe_frame(s0, s1, stable, both);
        checks++; if (!both || !stable) begin errors++; $display("FAIL mid_frame: both=%b stable=%b, required 1 1", both, stable); end
        checks++; if (s0 !== 7'h7F) begin errors++; $display("FAIL mid_ones: got %h, required 7f", s0); end
        checks++; if (s1 !== 7'h7F) begin errors++; $display("FAIL mid_tens: got %h, required 7f", s1); end
    endtask

    initial begin
        test_reset();
        test_value_42();
        test_boundary();
        test_sample_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
